lms_weight_update: RTL

Serial LMS coefficient updater feeding the 32-tap adaptive filter. After each filter pass it takes the 14-bit error sample and the reference tap-delay samples, computes w[i] += (e·x[i]) >>> MU_SHIFT with saturation for every tap, and holds the 32 coefficients the filter reads back. One shared multiplier is used, pipelined one tap per cycle.

---
 rtl/lms_weight_update.sv | 129 ++++++++++++
 1 files changed

// File: rtl/lms_weight_update.sv
// lms_weight_update: serial LMS coefficient updater for the adaptive filter.
// One shared multiplier, one tap per cycle; coefficients saturate on overflow.
//
// state | meaning
// IDLE  | waiting for start; w_clr clears coefficients here
// ISSUE | x_idx = 0..31, one product captured per cycle
// DRAIN | last product retires into the coefficient array
// DONE  | one-cycle done pulse, sat_flag valid
module lms_weight_update #(
  parameter int TAPS     = 32,
  parameter int XW       = 14,
  parameter int WW       = 32,
  parameter int MU_SHIFT = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic signed [XW-1:0] e,
  output logic [4:0]           x_idx,
  input  logic signed [XW-1:0] x_data,
  input  logic                 w_clr,
  input  logic [4:0]           w_rd_idx,
  output logic [WW-1:0]        w_rd_data,
  output logic                 busy,
  output logic                 done,
  output logic                 sat_flag
);

  localparam int PW = 2 * XW;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [4:0]            cnt_q;
  logic signed [XW-1:0]  e_q;
  logic signed [PW-1:0]  prod_q;
  logic signed [PW-1:0]  prod_d;
  logic [4:0]            idx_q;
  logic                  vld_q;
  logic                  sat_q;
  logic signed [WW-1:0]  w_q [TAPS];

  logic                  accept;
  logic                  clear;
  logic signed [PW-1:0]  shifted;
  logic signed [WW:0]    delta;
  logic signed [WW:0]    sum;
  logic                  ovf;
  logic signed [WW-1:0]  wr_val;

  assign accept    = (state_q == IDLE) && start;
  assign clear     = (state_q == IDLE) && !start && w_clr;
  assign x_idx     = (state_q == ISSUE) ? cnt_q : 5'd0;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign sat_flag  = sat_q;
  assign w_rd_data = w_q[w_rd_idx];
  assign prod_d    = PW'(e_q) * PW'(x_data);

  // Write-stage arithmetic: one guard bit on the sum detects overflow.
  always_comb begin
    shifted = prod_q >>> MU_SHIFT;
    delta   = (WW+1)'(shifted);
    sum     = (WW+1)'(w_q[idx_q]) + delta;
    ovf     = (sum[WW] != sum[WW-1]);
    wr_val  = sum[WW-1:0];
    if (ovf) begin
      wr_val = sum[WW] ? {1'b1, {(WW-1){1'b0}}} : {1'b0, {(WW-1){1'b1}}};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ISSUE;
      ISSUE:   if (cnt_q == 5'(TAPS - 1)) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Issue pipeline: latch error, step the tap counter, capture one product per cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      e_q    <= '0;
      cnt_q  <= '0;
      prod_q <= '0;
      idx_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= (state_q == ISSUE);
      if (accept) begin
        e_q   <= e;
        cnt_q <= '0;
      end else if (state_q == ISSUE) begin
        prod_q <= prod_d;
        idx_q  <= cnt_q;
        cnt_q  <= cnt_q + 5'd1;
      end
    end
  end

  // Coefficient array: idle clear or one saturated write per retired product.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < TAPS; i++) w_q[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < TAPS; i++) w_q[i] <= '0;
    end else if (vld_q) begin
      w_q[idx_q] <= wr_val;
    end
  end

  // Saturation flag: cleared on accept, sticky for the rest of the pass.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)              sat_q <= 1'b0;
    else if (accept)        sat_q <= 1'b0;
    else if (vld_q && ovf)  sat_q <= 1'b1;
  end

endmodule
